// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types for the data-memory arbiter: FSM states, port ids
//            and the memory request record.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_id_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pick
// Purpose  : Combinational winner selection between CPU and AUX requests.
//            DMEM_ARB_RR_EN selects round-robin; otherwise CPU has priority.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     cpu_req,
  input  logic     aux_req,
  input  port_id_t last_grant,
  output logic     valid,
  output port_id_t winner
);

  always_comb begin
    valid = cpu_req | aux_req;
`ifdef DMEM_ARB_RR_EN
    // On contention the master that did not win last time is served.
    if (cpu_req && aux_req) begin
      winner = (last_grant == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else begin
      winner = cpu_req ? PORT_CPU : PORT_AUX;
    end
`else
    winner = cpu_req ? PORT_CPU : PORT_AUX;
`endif
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Serialises CPU and AUX accesses onto a single-port synchronous
//            data RAM. Optional DMEM_ARB_RR_EN enables round-robin.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [BE_W-1:0]   aux_be,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  import dmem_arb_pkg::*;

  arb_state_t        state_q, state_d;
  port_id_t          owner_q, owner_d;
  logic              req_we_q, req_we_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  port_id_t last_grant;
  logic     pick_valid;
  port_id_t pick_winner;
  logic     in_access;
  logic     in_resp;

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .aux_req    (aux_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

`ifdef DMEM_ARB_RR_EN
  port_id_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && pick_valid) begin
      last_grant_d = pick_winner;
    end
  end

  // Reset value AUX makes the CPU the first winner under contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_AUX;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_AUX;
`endif

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_we_d    = req_we_q;
    req_be_d    = req_be_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cpu_rdata_d = cpu_rdata;
    aux_rdata_d = aux_rdata;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          owner_d = pick_winner;
          if (pick_winner == PORT_CPU) begin
            req_we_d    = cpu_we;
            req_be_d    = cpu_be;
            req_addr_d  = cpu_addr;
            req_wdata_d = cpu_wdata;
          end else begin
            req_we_d    = aux_we;
            req_be_d    = aux_be;
            req_addr_d  = aux_addr;
            req_wdata_d = aux_wdata;
          end
        end
      end
      ACCESS:  state_d = req_we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_we_q    <= req_we_d;
      req_be_q    <= req_be_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign cpu_gnt    = in_access && (owner_q == PORT_CPU);
  assign aux_gnt    = in_access && (owner_q == PORT_AUX);
  assign cpu_rvalid = in_resp && (owner_q == PORT_CPU);
  assign aux_rvalid = in_resp && (owner_q == PORT_AUX);

  // Read data passes straight through in RESP and is held afterwards.
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign aux_rdata  = aux_rvalid ? mem_rdata : aux_rdata_q;

  assign mem_addr   = req_addr_q;
  assign mem_wdata  = req_wdata_q;
  assign mem_we     = in_access && req_we_q;
  assign mem_be     = in_access ? req_be_q : '0;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter against a transaction-level
//            reference model; honours DMEM_ARB_RR_EN for the arbitration rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [BW-1:0] cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [BW-1:0] aux_be;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_be(aux_be), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous-read, byte-writable RAM attached to the arbiter
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdata;
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    ram_rdata <= ram[mem_addr];
  end
  assign mem_rdata = ram_rdata;

  typedef struct {
    bit            pend;
    bit            we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  mreq_t rq [2];
  bit    granted [2];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;

  // Reference model: one transaction in flight, timed from its start cycle
  bit            m_act;
  int            m_t0, m_own, m_last;
  bit            m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr, m_hold_addr;
  logic [DW-1:0] m_wdata, m_hold_wdata;
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            gnt_log[$];
  int            rv_cycles[$];
  logic [AW-1:0] pool [8] = '{10'h000, 10'h001, 10'h002, 10'h005,
                              10'h0FF, 10'h200, 10'h3FE, 10'h3FF};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_act        = 1'b0;
    m_t0         = -100;
    m_hold_addr  = '0;
    m_hold_wdata = '0;
    m_rdata[0]   = '0;
    m_rdata[1]   = '0;
    m_last       = 1;
  endfunction

  task automatic step_check();
    int ph;
    int w;
    bit e_gnt, e_rv;
    ph = cyc - m_t0;
    if (m_act && ph > (m_we ? 1 : 2)) m_act = 1'b0;
    e_gnt = m_act && ph == 1;
    e_rv  = m_act && !m_we && ph == 2;
    if (e_rv) m_rdata[m_own] = ref_mem[m_addr];
    chk("busy",       64'(busy),       64'(m_act));
    chk("cpu_gnt",    64'(cpu_gnt),    64'(e_gnt && m_own == 0));
    chk("aux_gnt",    64'(aux_gnt),    64'(e_gnt && m_own == 1));
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_rv && m_own == 0));
    chk("aux_rvalid", 64'(aux_rvalid), 64'(e_rv && m_own == 1));
    chk("cpu_rdata",  64'(cpu_rdata),  64'(m_rdata[0]));
    chk("aux_rdata",  64'(aux_rdata),  64'(m_rdata[1]));
    chk("mem_we",     64'(mem_we),     64'(e_gnt && m_we));
    chk("mem_be",     64'(mem_be),     e_gnt ? 64'(m_be) : 64'd0);
    chk("mem_addr",   64'(mem_addr),   64'(m_hold_addr));
    chk("mem_wdata",  64'(mem_wdata),  64'(m_hold_wdata));
    if (cpu_rvalid) rv_cycles.push_back(cyc);
    if (e_gnt) begin
      granted[m_own] = 1'b1;
      gnt_log.push_back(m_own);
      if (m_we) begin
        for (int b = 0; b < BW; b++) begin
          if (m_be[b]) ref_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
        end
      end
    end
    if (!m_act) begin
      w = -1;
      if (rq[0].pend && rq[1].pend) begin
`ifdef DMEM_ARB_RR_EN
        w = (m_last == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else if (rq[0].pend) begin
        w = 0;
      end else if (rq[1].pend) begin
        w = 1;
      end
      if (w >= 0) begin
        m_act        = 1'b1;
        m_t0         = cyc;
        m_own        = w;
        m_last       = w;
        m_we         = rq[w].we;
        m_be         = rq[w].be;
        m_addr       = rq[w].addr;
        m_wdata      = rq[w].wdata;
        m_hold_addr  = rq[w].addr;
        m_hold_wdata = rq[w].wdata;
      end
    end
  endtask

  task automatic tick();
    cpu_req = rq[0].pend; cpu_we = rq[0].we; cpu_be = rq[0].be;
    cpu_addr = rq[0].addr; cpu_wdata = rq[0].wdata;
    aux_req = rq[1].pend; aux_we = rq[1].we; aux_be = rq[1].be;
    aux_addr = rq[1].addr; aux_wdata = rq[1].wdata;
    #4;
    if (rst_n) step_check();
    cyc++;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (granted[m]) begin
        rq[m].pend = 1'b0;
        granted[m] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int m, input bit we, input logic [BW-1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    rq[m].pend = 1'b1; rq[m].we = we; rq[m].be = be;
    rq[m].addr = addr; rq[m].wdata = wd;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((rq[0].pend || rq[1].pend) && n < 60) begin
      tick();
      n++;
    end
    chk("settle_timeout", 64'({rq[0].pend, rq[1].pend}), 64'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rq[m].pend = 1'b0;
      granted[m] = 1'b0;
    end
    repeat (n) tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      rq[m] = '{1'b0, 1'b0, '0, '0, '0};
      granted[m] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // Idle after reset: every output is checked as zero by the model
    repeat (10) tick();

    // CPU write then read at 0x005
    issue(0, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF); settle();
    issue(0, 1'b0, 4'hF, 10'h005, 32'h0);        settle();
    chk("cpu_rd_005",   64'(cpu_rdata), 64'hDEADBEEF);
    chk("aux_rd_quiet", 64'(aux_rdata), 64'h0);

    // Byte write at the top address by AUX over a preloaded word
    issue(0, 1'b1, 4'hF, 10'h3FF, 32'h11223344); settle();
    issue(1, 1'b1, 4'h1, 10'h3FF, 32'h000000AB); settle();
    issue(1, 1'b0, 4'hF, 10'h3FF, 32'h0);        settle();
    chk("aux_rd_3ff", 64'(aux_rdata), 64'h112233AB);

    // Preload the random-address pool
    for (int k = 0; k < 8; k++) begin
      if (pool[k] != 10'h005 && pool[k] != 10'h3FF) begin
        issue(0, 1'b1, 4'hF, pool[k], $urandom);
        settle();
      end
    end

    // Reset asserted during the RESP cycle of a read
    issue(0, 1'b0, 4'hF, 10'h002, 32'h0);
    tick();
    tick();
    do_reset(1);
    tick();
    chk("rst_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_rdata",  64'(cpu_rdata),  64'd0);
    chk("rst_busy",   64'(busy),       64'd0);
    issue(0, 1'b0, 4'h0, 10'h005, 32'h0); settle();
    chk("rd_be0_after_rst", 64'(cpu_rdata), 64'hDEADBEEF);

    // Both masters requesting continuously
    do_reset(1);
    gnt_log.delete();
    n = 0;
    while (gnt_log.size() < 12 && n < 100) begin
      if (!rq[0].pend) issue(0, 1'b0, 4'hF, pool[$urandom_range(0, 7)], 32'h0);
      if (!rq[1].pend) issue(1, 1'b0, 4'hF, pool[$urandom_range(0, 7)], 32'h0);
      tick();
      n++;
    end
    for (int i = 0; i < 12; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk($sformatf("arb_order_%0d", i), 64'(i < gnt_log.size() ? gnt_log[i] : -1), 64'(i % 2));
`else
      chk($sformatf("arb_order_%0d", i), 64'(i < gnt_log.size() ? gnt_log[i] : -1), 64'd0);
`endif
    end
    settle();

    // Back-to-back CPU reads
    rv_cycles.delete();
    n = 0;
    for (int k = 0; k < 5 && n < 60; n++) begin
      if (!rq[0].pend) begin
        issue(0, 1'b0, 4'hF, pool[k], 32'h0);
        k++;
      end
      tick();
    end
    settle();
    chk("b2b_count", 64'(rv_cycles.size()), 64'd5);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("b2b_gap_%0d", k),
          64'(k < rv_cycles.size() ? rv_cycles[k] - rv_cycles[k-1] : -1), 64'd3);
    end

    // Randomised traffic from both masters
    repeat (400) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq[m].pend && $urandom_range(0, 3) == 0) begin
          issue(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                pool[$urandom_range(0, 7)], $urandom);
        end
      end
      tick();
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single-port, synchronous-read data memory between the CPU load/store path and an auxiliary master (program loader / debug port).
- Serialises requests, latches the winning request, drives the memory and returns read data to the owner.
- Sits between cpu/aux and the data memory RAM in the top level.

Parameters:
ADDR_W, 10, word-address width of the data memory
DATA_W, 32, data width; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU request; held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_be  in  BE_W  byte enables (writes only)
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  one-cycle grant; request consumed
cpu_rvalid  out  1  one-cycle read-data valid
cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
aux_req, aux_we, aux_be, aux_addr, aux_wdata  in  as cpu_*  auxiliary master request
aux_gnt, aux_rvalid, aux_rdata  out  as cpu_*  auxiliary master response
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write strobe
mem_be  out  BE_W  RAM byte enables
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: rst_n sampled on posedge clk, synchronous, active-low; clock clk.
  - State goes to IDLE and owner to CPU.
  - All outputs are 0: gnt, rvalid, rdata, mem_*, busy.
  - last_grant is set to AUX.
  - Reset in any state aborts the transaction: no gnt or rvalid follows, and mem_we drops at the next edge.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req is high, pick a winner, latch its we/be/addr/wdata and owner, and go to ACCESS. Otherwise stay.
  - ACCESS (1 cycle): mem_addr/mem_be/mem_wdata come from the latched request.
    - mem_we = latched we.
    - gnt of the owner = 1 for this cycle only.
    - Next state is RESP if read, IDLE if write.
  - RESP (1 cycle): owner's rvalid = 1 and rdata = mem_rdata (combinational pass-through); then go to IDLE.
- Outside RESP, rdata is held at its last returned value; rvalid = 0.
- mem_we and mem_be are 0 outside ACCESS. mem_addr and mem_wdata hold their last value.
- Latency from req rising in IDLE:
  - gnt at +1 cycle.
  - Read rvalid at +2 cycles.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Masters must keep req and request fields stable until gnt and must drop req (or present the next request) in the cycle after gnt. The arbiter samples requests only in IDLE.
- Priority: fixed, CPU wins when both request; AUX is served only when cpu_req = 0 in IDLE.
- A read with cpu_be = 0 is legal: full word returned. A write with be = 0 is legal: mem_we pulses and the RAM writes nothing.
- Simultaneous new req arriving in ACCESS/RESP: ignored until IDLE, with no loss because req is held.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - When both req are high in IDLE, grant the master that is not last_grant.
  - last_grant updates on every IDLE->ACCESS transition.
  - A single requester always wins.
- Undefined: fixed CPU priority as above; the last_grant register is not instantiated.

Decomposition:
Package dmem_arb_pkg:
- typedef enum arb_state_t {IDLE, ACCESS, RESP}
- typedef enum port_id_t {PORT_CPU, PORT_AUX}
- packed struct mem_req_t {we, be, addr, wdata}, parameterised via package localparams ADDR_W/DATA_W

Sub-module dmem_arb_pick:
- Purely combinational.
- Inputs: cpu_req, aux_req, last_grant.
- Outputs: valid, winner.
- Contains the RR/fixed `ifdef so the FSM is identical in both builds.

Test Plan:
- Reset then idle: all outputs 0, busy 0 for 10 cycles with no req.
- CPU write addr 0x005, wdata 0xDEADBEEF, be 0xF -> cpu_gnt at +1 with mem_we=1, mem_addr=0x005; state IDLE at +2. Then CPU read 0x005 -> cpu_rvalid at +2 with rdata 0xDEADBEEF; aux_* stays 0.
- AUX write 0x3FF byte be=0x1 data 0x000000AB over preloaded 0x11223344 -> AUX read 0x3FF returns 0x112233AB (wrap/top-address boundary).
- Both req every cycle for 12 transactions:
  - fixed build: all 12 grants go to CPU, AUX starved.
  - DMEM_ARB_RR_EN build: grants alternate CPU, AUX, CPU..., with CPU first after reset.
- Read in flight, rst_n=0 during RESP cycle -> no rvalid, rdata 0, busy 0 next cycle; a subsequent read completes normally.
- Back-to-back CPU reads while AUX idle -> rvalid every 3 cycles; busy low exactly one cycle between transactions.
